// File: rtl/sbc4_pcm_serializer.sv
// sbc4_pcm_serializer
// Takes one 4-sample PCM frame per handshake and buffers up to two frames in
// ping-pong slots. It replays the buffered frames as a serial stream, one
// sample per transfer, tagged with the frame's channel id and the sample's
// position within the frame.
module sbc4_pcm_serializer #(
   parameter int NR_CHANNELS   = 3,
   parameter int INPUT_WIDTH   = 16,
   parameter int CHANNEL_WIDTH = $clog2(NR_CHANNELS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [INPUT_WIDTH-1:0]   s_tdata0,
   input  logic [INPUT_WIDTH-1:0]   s_tdata1,
   input  logic [INPUT_WIDTH-1:0]   s_tdata2,
   input  logic [INPUT_WIDTH-1:0]   s_tdata3,
   input  logic [CHANNEL_WIDTH-1:0] s_tid,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   output logic [INPUT_WIDTH-1:0]   m_tdata,
   output logic [CHANNEL_WIDTH-1:0] m_tid,
   output logic [1:0]               m_tidx,
   output logic                     m_tlast,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   input  logic                     underrun_clr,
   output logic                     underrun
);

   // Frame storage: two slots of four samples plus a channel id each.
   logic [INPUT_WIDTH-1:0]   slot_data [2][4];
   logic [CHANNEL_WIDTH-1:0] slot_tid  [2];

   logic       wr;       // slot the next accepted frame goes into
   logic       rd;       // slot currently being streamed out
   logic [1:0] count;    // frames held: 0, 1 or 2
   logic [1:0] idx;      // sample position within the frame being read
   logic       started;  // set once the first frame has been accepted

   logic wr_en;
   logic rd_en;
   logic retire;

   // Handshake decode from registered state only; m_tready never reaches s_tready.
   always_comb begin
      s_tready = (count != 2'd2);
      m_tvalid = (count != 2'd0);
      wr_en    = s_tvalid && s_tready;
      rd_en    = m_tvalid && m_tready;
      retire   = rd_en && (idx == 2'd3);
   end

   // Output sample selected by read slot and sample index; stable while stalled.
   always_comb begin
      m_tdata = slot_data[rd][idx];
      m_tid   = slot_tid[rd];
      m_tidx  = idx;
      m_tlast = (idx == 2'd3);
   end

   // Capture an accepted frame into the write slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the slots are reset so that m_tdata/m_tid read as 0 out of reset;
         // the read mux is always looking at some slot, valid or not.
         for (int s = 0; s < 2; s++) begin
            slot_tid[s] <= '0;
            for (int k = 0; k < 4; k++) begin
               slot_data[s][k] <= '0;
            end
         end
      end else if (wr_en) begin
         // NOTE: non-blocking assignments on all state, so every register here
         // samples pre-edge values regardless of statement order.
         slot_data[wr][0] <= s_tdata0;
         slot_data[wr][1] <= s_tdata1;
         slot_data[wr][2] <= s_tdata2;
         slot_data[wr][3] <= s_tdata3;
         slot_tid[wr]     <= s_tid;
      end
   end

   // Write pointer, read pointer and sample index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr  <= 1'b0;
         rd  <= 1'b0;
         idx <= 2'd0;
      end else begin
         if (wr_en) begin
            wr <= ~wr;
         end
         if (rd_en) begin
            idx <= idx + 2'd1;   // wraps 3 -> 0 on retire
         end
         if (retire) begin
            rd <= ~rd;
         end
      end
   end

   // Occupancy: +1 on write, -1 on retire, unchanged when both happen together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
      end else begin
         case ({wr_en, retire})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Streaming-started flag and sticky underrun; a set beats a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (wr_en) begin
            started <= 1'b1;
         end
         if (started && m_tready && (count == 2'd0)) begin
            underrun <= 1'b1;
         end else if (underrun_clr) begin
            underrun <= 1'b0;
         end
      end
   end

endmodule
